a25_cache_flush_ctrl: RTL

A25_CACHE_FLUSH_CTRL -- requirements
Module: a25_cache_flush_ctrl

---
 rtl/a25_cache_flush_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/a25_cache_flush_ctrl.sv
// Cache flush sequencer: walks every tag RAM line index to invalidate it, coalescing
// flush requests that arrive mid-sweep, and registers the per-access cacheability decision.
module a25_cache_flush_ctrl #(
    parameter int unsigned LINES = 256,
    parameter int unsigned IDX_W = 8
) (
    input  logic             i_clk,
    input  logic             quick_n_reset,
    input  logic             i_access_stall,
    input  logic             i_cache_enable,
    input  logic             i_cache_flush,
    input  logic [31:0]      i_cacheable_area,
    input  logic [31:0]      i_address,
    output logic             o_cacheable,
    output logic             o_tag_wr_en,
    output logic [IDX_W-1:0] o_tag_wr_index,
    output logic             o_flush_busy
);

    typedef enum logic {StIdle, StFlush} state_t;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(LINES - 1);

    state_t           r_state;
    state_t           w_state_d;
    logic [IDX_W-1:0] r_count;
    logic [IDX_W-1:0] w_count_d;
    logic             r_pending;
    logic             w_pending_d;
    logic             r_enable_prev;
    logic             r_cacheable;
    logic             r_flush_busy;
    logic             w_flush_req;
    logic             w_cacheable_d;
    logic             w_unused;

    // Only the 2 MB region number selects cacheability.
    assign w_unused = ^{i_address[31:26], i_address[20:0]};

    // Explicit flush, or the cache being switched off.
    assign w_flush_req = ~i_access_stall & (i_cache_flush | (r_enable_prev & ~i_cache_enable));

    always_comb begin
        w_state_d   = r_state;
        w_count_d   = r_count;
        w_pending_d = r_pending;
        if (!i_access_stall) begin
            unique case (r_state)
                StIdle: begin
                    if (w_flush_req) begin
                        w_state_d = StFlush;
                        w_count_d = '0;
                    end
                end
                StFlush: begin
                    if (r_count == LastIdx) begin
                        // A request landing on the final write restarts the sweep.
                        if (r_pending || w_flush_req) begin
                            w_pending_d = 1'b0;
                            w_count_d   = '0;
                        end else begin
                            w_state_d = StIdle;
                            w_count_d = '0;
                        end
                    end else begin
                        w_count_d = r_count + 1'b1;
                        if (w_flush_req) begin
                            w_pending_d = 1'b1;
                        end
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    assign w_cacheable_d = i_cache_enable & i_cacheable_area[i_address[25:21]]
                           & (w_state_d != StFlush);

    always_ff @(posedge i_clk or negedge quick_n_reset) begin
        if (!quick_n_reset) begin
            r_state       <= StIdle;
            r_count       <= '0;
            r_pending     <= 1'b0;
            r_enable_prev <= 1'b0;
            r_cacheable   <= 1'b0;
            r_flush_busy  <= 1'b0;
        end else if (!i_access_stall) begin
            r_state       <= w_state_d;
            r_count       <= w_count_d;
            r_pending     <= w_pending_d;
            r_enable_prev <= i_cache_enable;
            r_cacheable   <= w_cacheable_d;
            r_flush_busy  <= (w_state_d == StFlush);
        end
    end

    assign o_tag_wr_en    = (r_state == StFlush) & ~i_access_stall;
    assign o_tag_wr_index = (r_state == StFlush) ? r_count : '0;
    assign o_cacheable    = r_cacheable;
    assign o_flush_busy   = r_flush_busy;

endmodule
